assert_sched: RTL
=================

ASSERT_SCHED -- requirements
Module: assert_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of guarded check requesters (2..16).
REQ-002 Parameter HOLDOFF, default 8, cycles of enabled operation after reset or re-enable before checks are accepted (>=1).
REQ-003 Parameter CNT_W, default 8, width of failure counter.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 ASYNCRESETN  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  runtime assertion enable (global guard).
REQ-007 req_valid  input  N_REQ  per-requester check event pending.
REQ-008 req_fail  input  N_REQ  per-requester check result, 1 = violation, qualified by req_valid.
REQ-009 req_ready  output  N_REQ  one-hot accept; at most one bit high per cycle.
REQ-010 rpt_valid  output  1  report channel valid.
REQ-011 rpt_ready  input  1  report channel ready.
REQ-012 rpt_id  output  clog2(N_REQ)  index of reported requester.
REQ-013 rpt_fail  output  1  reported check result.
REQ-014 fail_cnt  output  CNT_W  saturating count of reported failures.
REQ-015 sticky_fail  output  N_REQ  per-requester latched failure flag.
REQ-016 armed  output  1  high when not in HOLDOFF state.

Function
REQ-017 FSM states SHALL be HOLDOFF, IDLE, REPORT.
REQ-018 HOLDOFF: counter increments each cycle en=1, holds when en=0; on count reaching HOLDOFF-1 with en=1 -> IDLE next cycle, counter cleared.
REQ-019 IDLE: en=0 -> HOLDOFF with counter cleared; no grant that cycle.
REQ-020 IDLE, en=1, any req_valid: round-robin grant g = first valid index at or above pointer ptr (wrapping); req_ready[g]=1 combinationally that cycle.
REQ-021 On grant: rpt_id<=g, rpt_fail<=req_fail[g], ptr<=(g+1) mod N_REQ, -> REPORT; rpt_valid high the following cycle (grant-to-report latency 1).
REQ-022 REPORT: rpt_valid=1, rpt_id/rpt_fail stable until rpt_valid&&rpt_ready; req_ready all zero.
REQ-023 REPORT handshake -> IDLE if en=1, else HOLDOFF; in-flight report SHALL never be dropped when en falls.
REQ-024 No grant in the handshake cycle; maximum throughput one report per 2 cycles.
REQ-025 req_ready SHALL be zero in HOLDOFF and REPORT.
REQ-026 On handshake with rpt_fail=1: fail_cnt increments, saturating at 2^CNT_W-1; sticky_fail[rpt_id] set.
REQ-027 sticky_fail and fail_cnt cleared only by reset, unaffected by en.
REQ-028 Requesters hold req_valid/req_fail until accepted; a valid dropped before grant is simply not reported.
REQ-029 ptr unchanged when no grant occurs.

Reset
REQ-030 Asserting ASYNCRESETN low SHALL immediately force: state HOLDOFF, counter 0, ptr 0, rpt_valid 0, rpt_id 0, rpt_fail 0, fail_cnt 0, sticky_fail 0, armed 0, req_ready 0.
REQ-031 Reset mid-REPORT SHALL abandon the report without counting it.
REQ-032 Reset deassertion is synchronized externally; block leaves reset on first rising edge after release.

Structure
REQ-033 Shared package holds state enum, parameter defaults, and id-width helper function.
REQ-034 One sub-module assert_sched_rr: combinational round-robin select (req vector, ptr -> one-hot grant, index, any).
REQ-035 FSM, holdoff counter, report register, counters live in assert_sched top.

Verification (N_REQ=4, HOLDOFF=8, CNT_W=8)
REQ-036 Reset release, en=1, req_valid=4'b0001 from cycle 0 -> req_ready stays 0 for 8 cycles, armed rises cycle 8, grant cycle 8, rpt_valid cycle 9.
REQ-037 req_valid=4'b1111 held, rpt_ready=1 -> rpt_id sequence 0,1,2,3,0 at one report per 2 cycles.
REQ-038 Requester 2 fail, rpt_ready=0 for 5 cycles -> rpt_valid/rpt_id=2/rpt_fail=1 stable 5 cycles; on ready fail_cnt=1, sticky_fail=4'b0100.
REQ-039 300 fail reports -> fail_cnt saturates at 255.
REQ-040 en dropped during REPORT -> report completes, then armed=0 and 8 enabled cycles required before next grant.
REQ-041 ASYNCRESETN low mid-REPORT with rpt_ready=0 -> rpt_valid, fail_cnt, sticky_fail zero immediately, without clock edge.

Source files
------------

// File: rtl/assert_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : assert_sched_pkg
// Description : Shared definitions for the assertion-check scheduler.
//               Holds the FSM state encoding, parameter defaults and the
//               helper used to size requester-index and counter fields.
// Revision    : 1.0 - initial release
// ============================================================================
package assert_sched_pkg;

    // Scheduler FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_HOLDOFF = 2'd0,
        ST_IDLE    = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    // Parameter defaults shared by the top and any wrappers.
    localparam int C_N_REQ_DEFAULT   = 4;
    localparam int C_HOLDOFF_DEFAULT = 8;
    localparam int C_CNT_W_DEFAULT   = 8;

    // Width needed to hold an index in [0, n-1]; never narrower than 1 bit
    // so that degenerate sizes still produce a legal vector.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : assert_sched_pkg
`default_nettype wire

// File: rtl/assert_sched_rr.sv
`default_nettype none
// ============================================================================
// Module      : assert_sched_rr
// Description : Combinational round-robin selector. Picks the first asserted
//               request at or above the priority pointer, wrapping around.
// Ports       : req   [N_REQ-1:0] in  - pending request vector
//               ptr   [IDW-1:0]   in  - highest-priority index this cycle
//               grant [N_REQ-1:0] out - one-hot selection (zero if none)
//               idx   [IDW-1:0]   out - index of selection (zero if none)
//               any               out - at least one request pending
// Revision    : 1.0 - initial release
// ============================================================================
module assert_sched_rr #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    // Walk N_REQ slots starting at ptr. The sum is one bit wider than an
    // index so ptr + offset cannot overflow before the modulo wrap.
    always_comb begin
        logic [IDW:0] w_sum;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_sum = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, ptr} + (IDW+1)'(i);
            if (w_sum >= (IDW+1)'(N_REQ)) begin
                w_sum = w_sum - (IDW+1)'(N_REQ);
            end
            if (!any && req[w_sum[IDW-1:0]]) begin
                any                     = 1'b1;
                grant[w_sum[IDW-1:0]]   = 1'b1;
                idx                     = w_sum[IDW-1:0];
            end
        end
    end

endmodule : assert_sched_rr
`default_nettype wire

// File: rtl/assert_sched.sv
`default_nettype none
// ============================================================================
// Module      : assert_sched
// Description : Guarded scheduler for runtime assertion checks. After a
//               hold-off period of enabled cycles it accepts check events
//               from N_REQ requesters in round-robin order, forwards each
//               one on a valid/ready report channel, and tracks failures in
//               a saturating counter plus per-requester sticky flags.
// Ports       : CLK          in  - clock, all state on rising edge
//               ASYNCRESETN  in  - asynchronous active-low reset
//               en           in  - global assertion enable
//               req_valid    in  - per-requester check event pending
//               req_fail     in  - per-requester check result (1 = violation)
//               req_ready    out - one-hot accept, combinational in IDLE
//               rpt_valid    out - report channel valid
//               rpt_ready    in  - report channel ready
//               rpt_id       out - index of reported requester
//               rpt_fail     out - reported check result
//               fail_cnt     out - saturating count of reported failures
//               sticky_fail  out - per-requester latched failure flags
//               armed        out - scheduler is past hold-off
// Revision    : 1.0 - initial release
// ============================================================================
module assert_sched
    import assert_sched_pkg::*;
#(
    parameter int N_REQ   = C_N_REQ_DEFAULT,
    parameter int HOLDOFF = C_HOLDOFF_DEFAULT,
    parameter int CNT_W   = C_CNT_W_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       ASYNCRESETN,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_fail,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rpt_valid,
    input  logic                       rpt_ready,
    output logic [id_width(N_REQ)-1:0] rpt_id,
    output logic                       rpt_fail,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic [N_REQ-1:0]           sticky_fail,
    output logic                       armed
);

    localparam int IDW = id_width(N_REQ);
    localparam int HCW = id_width(HOLDOFF);

    localparam logic [HCW-1:0]   C_HOLD_LAST = HCW'(HOLDOFF - 1);
    localparam logic [IDW-1:0]   C_LAST_ID   = IDW'(N_REQ - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    state_t             r_state;
    logic [HCW-1:0]     r_hold_cnt;
    logic [IDW-1:0]     r_ptr;
    logic               r_rpt_valid;
    logic [IDW-1:0]     r_rpt_id;
    logic               r_rpt_fail;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [N_REQ-1:0]   r_sticky;

    logic [N_REQ-1:0]   w_rr_grant;
    logic [IDW-1:0]     w_rr_idx;
    logic               w_rr_any;
    logic               w_grant;
    logic [IDW-1:0]     w_ptr_next;

    assert_sched_rr #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_rr_grant),
        .idx   (w_rr_idx),
        .any   (w_rr_any)
    );

    // A grant only happens in IDLE while enabled; the en=0 cycle in IDLE
    // is spent returning to hold-off instead.
    assign w_grant    = (r_state == ST_IDLE) && en && w_rr_any;
    assign w_ptr_next = (w_rr_idx == C_LAST_ID) ? '0 : w_rr_idx + IDW'(1);

    // Single FSM process; the report register, pointer, hold-off counter and
    // failure bookkeeping all update alongside the state.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state     <= ST_HOLDOFF;
            r_hold_cnt  <= '0;
            r_ptr       <= '0;
            r_rpt_valid <= 1'b0;
            r_rpt_id    <= '0;
            r_rpt_fail  <= 1'b0;
            r_fail_cnt  <= '0;
            r_sticky    <= '0;
        end else begin
            case (r_state)
                ST_HOLDOFF: begin
                    // Only enabled cycles count toward arming.
                    if (en) begin
                        if (r_hold_cnt == C_HOLD_LAST) begin
                            r_state    <= ST_IDLE;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HCW'(1);
                        end
                    end
                end

                ST_IDLE: begin
                    if (!en) begin
                        r_state    <= ST_HOLDOFF;
                        r_hold_cnt <= '0;
                    end else if (w_grant) begin
                        r_state     <= ST_REPORT;
                        r_rpt_valid <= 1'b1;
                        r_rpt_id    <= w_rr_idx;
                        r_rpt_fail  <= req_fail[w_rr_idx];
                        r_ptr       <= w_ptr_next;
                    end
                end

                ST_REPORT: begin
                    // The report is held regardless of en; only the
                    // handshake retires it, so nothing in flight is lost.
                    if (rpt_ready) begin
                        r_rpt_valid <= 1'b0;
                        if (r_rpt_fail) begin
                            if (r_fail_cnt != C_CNT_MAX) begin
                                r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                            end
                            r_sticky[r_rpt_id] <= 1'b1;
                        end
                        if (en) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_HOLDOFF;
                            r_hold_cnt <= '0;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_HOLDOFF;
                    r_hold_cnt  <= '0;
                    r_rpt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = w_grant ? w_rr_grant : '0;
    assign rpt_valid   = r_rpt_valid;
    assign rpt_id      = r_rpt_id;
    assign rpt_fail    = r_rpt_fail;
    assign fail_cnt    = r_fail_cnt;
    assign sticky_fail = r_sticky;
    assign armed       = (r_state != ST_HOLDOFF);

endmodule : assert_sched
`default_nettype wire
